// File: rtl/qr_gs_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : qr_gs_sequencer
// Brief    : Command sequencer for a shared classical Gram-Schmidt datapath.
//            Walks the DOT/AXPY/NORM/SCALE schedule over N columns, issuing
//            one command at a time on a valid/ready port and waiting for the
//            matching completion pulse before moving on.
// Revision : 1.0 - initial release
// ============================================================================
module qr_gs_sequencer #(
  parameter int N       = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [1:0]       op_code,
  output logic [IDX_W-1:0] op_src,
  output logic [IDX_W-1:0] op_dst,
  input  logic             op_done,
  input  logic             op_zero,
  output logic [7:0]       op_count
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(N - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [1:0]       ERR_NONE = 2'd0;
  localparam logic [1:0]       ERR_ZERO = 2'd1;
  localparam logic [1:0]       ERR_TMO  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_DOT   = 2'd0,
    OP_AXPY  = 2'd1,
    OP_NORM  = 2'd2,
    OP_SCALE = 2'd3
  } op_t;

  state_t           state_q, state_d;
  op_t              phase_q, phase_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             op_valid_q, op_valid_d;
  logic [7:0]       op_count_q, op_count_d;

  // i is the basis column; it is parked on j for NORM/SCALE so op_src == j.
  logic             w_more_basis;
  assign w_more_basis = ({1'b0, i_q} + (IDX_W + 1)'(1)) < {1'b0, j_q};

  // Next-state, schedule advance and output decode.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    i_d        = i_q;
    j_d        = j_q;
    tmo_d      = tmo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    err_code_d = err_code_q;
    op_valid_d = op_valid_q;
    op_count_d = op_count_q;

    case (state_q)
      S_IDLE, S_ERR, S_DONE: begin
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
        if (start) begin
          // Every run begins with NORM(0,0): column 0 has no basis to remove.
          state_d    = S_ISSUE;
          phase_d    = OP_NORM;
          i_d        = '0;
          j_d        = '0;
          tmo_d      = '0;
          busy_d     = 1'b1;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          op_count_d = '0;
          op_valid_d = 1'b1;
        end
      end

      S_ISSUE: begin
        if (op_ready) begin
          state_d    = S_WAIT;
          op_valid_d = 1'b0;
          tmo_d      = '0;
        end
      end

      S_WAIT: begin
        if (op_done) begin
          if (op_count_q != 8'hFF) begin
            op_count_d = op_count_q + 8'd1;
          end
          state_d    = S_ISSUE;
          op_valid_d = 1'b1;
          case (phase_q)
            OP_DOT: phase_d = OP_AXPY;
            OP_AXPY: begin
              if (w_more_basis) begin
                phase_d = OP_DOT;
                i_d     = i_q + IDX_W'(1);
              end else begin
                phase_d = OP_NORM;
                i_d     = j_q;
              end
            end
            OP_NORM: begin
              if (op_zero) begin
                // Column is linearly dependent: scaling would divide by zero.
                state_d    = S_ERR;
                op_valid_d = 1'b0;
                busy_d     = 1'b0;
                error_d    = 1'b1;
                err_code_d = ERR_ZERO;
              end else begin
                phase_d = OP_SCALE;
              end
            end
            default: begin
              if (j_q == LAST_COL) begin
                state_d    = S_DONE;
                op_valid_d = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
              end else begin
                phase_d = OP_DOT;
                i_d     = '0;
                j_d     = j_q + IDX_W'(1);
              end
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          state_d    = S_ERR;
          busy_d     = 1'b0;
          error_d    = 1'b1;
          err_code_d = ERR_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: begin
        state_d    = S_IDLE;
        op_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any run in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= OP_DOT;
      i_q        <= '0;
      j_q        <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      op_valid_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      i_q        <= i_d;
      j_q        <= j_d;
      tmo_q      <= tmo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      op_valid_q <= op_valid_d;
      op_count_q <= op_count_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = err_code_q;
  assign op_valid = op_valid_q;
  assign op_code  = phase_q;
  assign op_src   = i_q;
  assign op_dst   = j_q;
  assign op_count = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_qr_gs_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_qr_gs_sequencer
// Brief    : Directed bench for qr_gs_sequencer. An N=2 instance and an N=4
//            (TIMEOUT=8) instance share stimulus; sel picks which one is
//            started and observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qr_gs_sequencer;

  localparam logic [1:0] DOT   = 2'd0;
  localparam logic [1:0] AXPY  = 2'd1;
  localparam logic [1:0] NORM  = 2'd2;
  localparam logic [1:0] SCALE = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, op_ready, op_done, op_zero, sel;
  logic start2, start4;
  assign start2 = start & ~sel;
  assign start4 = start & sel;

  logic       busy2, done2, error2, valid2;
  logic [1:0] ecode2, code2;
  logic [0:0] src2, dst2;
  logic [7:0] cnt2;
  logic       busy4, done4, error4, valid4;
  logic [1:0] ecode4, code4, src4, dst4;
  logic [7:0] cnt4;

  qr_gs_sequencer #(.N(2), .IDX_W(1), .TIMEOUT(64)) u_dut2 (
    .clk(clk), .reset(rst), .start(start2), .busy(busy2), .done(done2),
    .error(error2), .err_code(ecode2), .op_valid(valid2), .op_ready(op_ready),
    .op_code(code2), .op_src(src2), .op_dst(dst2), .op_done(op_done),
    .op_zero(op_zero), .op_count(cnt2)
  );

  qr_gs_sequencer #(.N(4), .IDX_W(2), .TIMEOUT(8)) u_dut4 (
    .clk(clk), .reset(rst), .start(start4), .busy(busy4), .done(done4),
    .error(error4), .err_code(ecode4), .op_valid(valid4), .op_ready(op_ready),
    .op_code(code4), .op_src(src4), .op_dst(dst4), .op_done(op_done),
    .op_zero(op_zero), .op_count(cnt4)
  );

  logic       busy, done, error, op_valid;
  logic [1:0] err_code, op_code, op_src, op_dst;
  logic [7:0] op_count;
  assign busy     = sel ? busy4  : busy2;
  assign done     = sel ? done4  : done2;
  assign error    = sel ? error4 : error2;
  assign err_code = sel ? ecode4 : ecode2;
  assign op_valid = sel ? valid4 : valid2;
  assign op_code  = sel ? code4  : code2;
  assign op_src   = sel ? src4   : {1'b0, src2};
  assign op_dst   = sel ? dst4   : {1'b0, dst2};
  assign op_count = sel ? cnt4   : cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One command: bounded wait for valid, optional ready stall with field
  // hold checks, accept, then op_done 3 cycles after the accept edge.
  task automatic do_cmd(input logic [1:0] code, input int src, input int dst,
                        input int rdy_wait, input bit zero, input bit poke,
                        input int exp_cnt);
    int k = 0;
    while (op_valid !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("op_valid", op_valid, 1);
    chk("op_code", op_code, code);
    chk("op_src", op_src, src);
    chk("op_dst", op_dst, dst);
    for (int r = 0; r < rdy_wait; r++) begin
      tick();
      chk("hold_valid", op_valid, 1);
      chk("hold_fields", {op_code, op_src, op_dst}, {code, 2'(src), 2'(dst)});
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk("valid_drop", op_valid, 0);
    tick();
    if (poke) start = 1'b1;
    tick();
    start = 1'b0;
    op_done = 1'b1;
    op_zero = zero;
    tick();
    op_done = 1'b0;
    op_zero = 1'b0;
    chk("op_count", op_count, exp_cnt);
  endtask

  // Reference Gram-Schmidt command order, replayed for the first `count` ops.
  task automatic run_seq(input int n, input int count, input int rdy_idx,
                         input int zero_idx, input int poke_idx);
    logic [1:0] c[$];
    int         s[$];
    int         d[$];
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < j; i++) begin
        c.push_back(DOT);  s.push_back(i); d.push_back(j);
        c.push_back(AXPY); s.push_back(i); d.push_back(j);
      end
      c.push_back(NORM);  s.push_back(j); d.push_back(j);
      c.push_back(SCALE); s.push_back(j); d.push_back(j);
    end
    for (int k = 0; k < count; k++) begin
      do_cmd(c[k], s[k], d[k], (k == rdy_idx) ? 5 : 0, (k == zero_idx),
             (k == poke_idx), k + 1);
    end
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; start = 1'b0;
    op_ready = 1'b0; op_done = 1'b0; op_zero = 1'b0;
    tick();
    tick();
    chk("rst_outs_n2", {busy2, done2, error2, ecode2, valid2, code2, src2, dst2, cnt2}, 0);
    chk("rst_outs_n4", {busy4, done4, error4, ecode4, valid4, code4, src4, dst4, cnt4}, 0);
    rst = 1'b0;
    tick();

    // N=2 full run
    start = 1'b1; tick(); start = 1'b0;
    chk("n2_busy", busy, 1);
    run_seq(2, 6, -1, -1, -1);
    chk("n2_done_busy", {done, busy}, 2'b10);
    chk("n2_count", op_count, 6);
    tick();
    chk("n2_done_pulse", {done, busy}, 2'b00);

    // spurious op_done while idle
    op_done = 1'b1; tick(); op_done = 1'b0; tick();
    chk("idle_spurious", {busy, op_valid, op_count}, {2'b00, 8'd6});

    // N=4 full run with stalls, spurious done/zero, start while busy
    sel = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("n4_busy", busy, 1);
    op_done = 1'b1; op_zero = 1'b1; tick(); op_done = 1'b0; op_zero = 1'b0;
    chk("issue_spurious", {op_valid, op_count}, {1'b1, 8'd0});
    start = 1'b1; tick(); start = 1'b0;
    chk("issue_start", {busy, op_code, op_count}, {1'b1, NORM, 8'd0});
    run_seq(4, 20, 2, 2, 5);
    chk("n4_done_busy", {done, busy, error}, 3'b100);
    chk("n4_count", op_count, 20);
    tick();
    chk("n4_done_pulse", done, 0);

    // zero norm on NORM(1,1)
    start = 1'b1; tick(); start = 1'b0;
    run_seq(4, 5, -1, 4, -1);
    chk("zero_err", {error, err_code, busy, op_valid}, {1'b1, 2'd1, 2'b00});
    for (int k = 0; k < 4; k++) tick();
    chk("zero_no_scale", {op_valid, op_count}, {1'b0, 8'd5});
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_clear", {error, err_code, op_count, busy}, {3'b000, 8'd0, 1'b1});
    chk("restart_cmd", {op_valid, op_code, op_src, op_dst}, {1'b1, NORM, 4'd0});

    // timeout: accept NORM(0,0) and never complete it
    op_ready = 1'b1; tick(); op_ready = 1'b0;
    chk("tmo_accept", op_valid, 0);
    for (int k = 0; k < 7; k++) tick();
    chk("tmo_early", {error, busy}, 2'b01);
    tick();
    chk("tmo_err", {error, err_code, busy, op_valid}, {1'b1, 2'd2, 2'b00});
    tick();
    chk("tmo_hold", {error, op_valid}, 2'b10);

    // reset during WAIT of DOT(1,2), then full replay
    start = 1'b1; tick(); start = 1'b0;
    run_seq(4, 8, -1, -1, -1);
    do begin
      int k = 0;
      while (op_valid !== 1'b1 && k < 50) begin tick(); k++; end
    end while (0);
    chk("dot12_fields", {op_valid, op_code, op_src, op_dst}, {1'b1, DOT, 2'd1, 2'd2});
    op_ready = 1'b1; tick(); op_ready = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {busy, done, error, err_code, op_valid, op_code, op_src, op_dst, op_count}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst", {busy, op_valid, op_count}, 0);
    start = 1'b1; tick(); start = 1'b0;
    run_seq(4, 20, -1, -1, -1);
    chk("replay_done", {done, busy, op_count}, {2'b10, 8'd20});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qr_gs_sequencer.md
Name: qr_gs_sequencer

Overview:
- Sequences a shared Gram-Schmidt datapath (dot-product, norm, divide/scale units over a column register file) to orthonormalise an N-column matrix into Q (and R entries).
- Issues one column operation at a time over a valid/ready command port and waits for a completion pulse before issuing the next.
- Sits between the precoder top-level control (start/done) and the QR datapath, which holds the column data.

Parameters:
- N, 4, number of matrix columns (2..16).
- IDX_W, 2, column index width; must be at least clog2(N).
- TIMEOUT, 64, maximum cycles in WAIT without op_done before an error is raised.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin factorisation; sampled only in IDLE, ERR or DONE.
- busy  output  1  high from accepted start until DONE or ERR.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky error flag; cleared by the next accepted start.
- err_code  output  2  0 none, 1 zero norm, 2 timeout; held with error.
- op_valid  output  1  command valid.
- op_ready  input  1  datapath accepts command.
- op_code  output  2  0 DOT (r_ij = <q_i, a_j>), 1 AXPY (a_j -= r_ij*q_i), 2 NORM (r_jj = ||a_j||), 3 SCALE (q_j = a_j / r_jj).
- op_src  output  IDX_W  i (source/basis column); equals j for NORM and SCALE.
- op_dst  output  IDX_W  j (target column).
- op_done  input  1  one-cycle completion pulse for the outstanding command.
- op_zero  input  1  valid with op_done on NORM; result is zero.
- op_count  output  8  commands completed in the current run.

Behaviour:
- Reset: all outputs 0; state IDLE; loop indices i = 0, j = 0; timeout counter 0. Reset asserted mid-operation aborts the run immediately. No command remains pending after reset.
- States: IDLE, ISSUE, WAIT, DONE, ERR.
  - IDLE/DONE/ERR + start: go to ISSUE; j = 0, i = 0; phase = (j == 0 ? NORM : DOT); busy = 1; error, err_code and op_count cleared.
  - ISSUE: op_valid = 1; op_code, op_src and op_dst are stable while op_valid is high. On op_ready: go to WAIT, op_valid = 0 the next cycle, timeout counter = 0.
  - WAIT: the counter increments every cycle. On op_done: op_count++, advance the schedule, go to ISSUE (or DONE after the last SCALE). If the counter reaches TIMEOUT - 1 with no op_done: go to ERR, err_code = 2.
  - NORM completion with op_zero = 1: go to ERR, err_code = 1; the SCALE for that column is not issued.
  - DONE: done = 1 for exactly one cycle, busy = 0; then IDLE unless start is high that cycle.
  - ERR: busy = 0, error = 1, op_valid = 0; held until start or reset.
- Schedule (classical Gram-Schmidt with in-place update):
  - For j = 0..N-1: for i = 0..j-1, issue DOT(i,j) then AXPY(i,j); then NORM(j,j), then SCALE(j,j).
  - Phase transitions:
    - DOT -> AXPY at the same i.
    - AXPY -> DOT at i+1 if i+1 < j; otherwise AXPY -> NORM.
    - NORM -> SCALE.
    - SCALE -> DOT(0, j+1), or NORM(0,0) style start for j = 0 handled at start; after j = N-1 the run ends.
  - Total commands = N*(N+1): 6 for N = 2, 20 for N = 4.
- Handshake rules:
  - At most one command is outstanding.
  - op_done seen outside WAIT is ignored (no count, no state change).
  - op_done in the same cycle as op_ready acceptance is ignored; the datapath latency is at least 1 cycle.
  - op_zero is ignored unless the outstanding op is NORM.
- start while busy is ignored.
- op_count saturates at 255.

Test Plan:
- N=2, op_ready tied 1, op_done 3 cycles after each accept -> exact sequence NORM(0,0), SCALE(0,0), DOT(0,1), AXPY(0,1), NORM(1,1), SCALE(1,1); one done pulse; op_count = 6; busy falls in the same cycle done rises.
- N=4, op_ready low for 5 cycles on the third command -> op_valid and its fields are held stable throughout; total of 20 commands; the final command is SCALE(3,3).
- N=4, op_zero = 1 on NORM(1,1) -> ERR with err_code = 1, SCALE(1,1) never issued, op_count = 5; a new start clears error and restarts at NORM(0,0).
- TIMEOUT=8, op_done withheld after the first accept -> error = 1 and err_code = 2 exactly 8 cycles after acceptance; op_valid stays 0.
- Spurious op_done in IDLE and in ISSUE, plus start pulsed while busy -> no state change, op_count unchanged, run unaffected.
- reset asserted during WAIT of DOT(1,2) -> all outputs 0 asynchronously; a subsequent start replays the full sequence from NORM(0,0).
